// File: rtl/intdiv_recon.sv
// Integer division check: rebuilds the dividend x = z*y + r from quotient,
// divisor and remainder with a serial radix-2 Booth multiplier and a final add.
module intdiv_recon #(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   z,
    input  logic [N-1:0]   y,
    input  logic [N-1:0]   r,
    output logic [2*N-1:0] x,
    output logic           ovf,
    output logic           busy,
    output logic           done
);

    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        ADD  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t         state_r;
    state_t         state_s;
    logic [2*N:0]   acc_r;
    logic           qm1_r;
    logic [N-1:0]   y_r;
    logic [N-1:0]   r_r;
    logic [CW-1:0]  cnt_r;
    logic           accept_s;
    logic           busy_s;
    logic           done_s;
    logic [2*N-1:0] sum_s;

    // One Booth step: the upper field is N+1 bits wide so that subtracting
    // -2^(N-1) can never wrap, then the whole accumulator shifts arithmetically.
    function automatic logic [2*N:0] booth_step(input logic [2*N:0] acc,
                                                input logic         qm1,
                                                input logic [N-1:0] md);
        logic [N:0] hi;
        logic [N:0] md_ext;
        hi     = acc[2*N:N];
        md_ext = {md[N-1], md};
        case ({acc[0], qm1})
            2'b01:   hi = hi + md_ext;
            2'b10:   hi = hi - md_ext;
            default: hi = hi;
        endcase
        return {hi[N], hi, acc[N-1:1]};
    endfunction

    // Result does not fit in N signed bits when the top N+1 bits disagree.
    function automatic logic ovf_of(input logic [2*N-1:0] v);
        logic [N:0] top;
        top = v[2*N-1:N-1];
        return !((&top) || (~|top));
    endfunction

    assign sum_s = acc_r[2*N-1:0] + {{N{r_r[N-1]}}, r_r};

    // State register with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode and next values of the status outputs.
    always_comb begin
        state_s  = state_r;
        accept_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    accept_s = 1'b1;
                    state_s  = MUL;
                end else begin
                    state_s  = IDLE;
                end
            end
            MUL: begin
                if (cnt_r == CW'(N - 1)) begin
                    state_s = ADD;
                end else begin
                    state_s = MUL;
                end
            end
            ADD: begin
                state_s = DONE;
            end
            DONE: begin
                if (start) begin
                    accept_s = 1'b1;
                    state_s  = MUL;
                end else begin
                    state_s  = IDLE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
        busy_s = (state_s == MUL) || (state_s == ADD);
        done_s = (state_s == DONE);
    end

    // Registered status outputs, aligned with the state they describe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= busy_s;
            done <= done_s;
        end
    end

    // Datapath: operand capture, Booth iterations, final add into x/ovf.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_r <= {(2*N+1){1'b0}};
            qm1_r <= 1'b0;
            y_r   <= {N{1'b0}};
            r_r   <= {N{1'b0}};
            cnt_r <= {CW{1'b0}};
            x     <= {(2*N){1'b0}};
            ovf   <= 1'b0;
        end else if (accept_s) begin
            // Multiplier goes in the low field; upper field starts at zero.
            acc_r <= {{(N+1){1'b0}}, z};
            qm1_r <= 1'b0;
            y_r   <= y;
            r_r   <= r;
            cnt_r <= {CW{1'b0}};
        end else begin
            case (state_r)
                MUL: begin
                    acc_r <= booth_step(acc_r, qm1_r, y_r);
                    qm1_r <= acc_r[0];
                    cnt_r <= cnt_r + CW'(1);
                end
                ADD: begin
                    x   <= sum_s;
                    ovf <= ovf_of(sum_s);
                end
                default: begin
                    acc_r <= acc_r;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_intdiv_recon.sv
// Self-checking bench for intdiv_recon (N=4): directed table, timing corner
// sequences, exhaustive sweep and random operands against an arithmetic model.
module tb_intdiv_recon;

    localparam int N = 4;

    logic           clk;
    logic           rst;
    logic           start;
    logic [N-1:0]   z;
    logic [N-1:0]   y;
    logic [N-1:0]   r;
    logic [2*N-1:0] x;
    logic           ovf;
    logic           busy;
    logic           done;

    int n_checks;
    int n_fail;

    intdiv_recon #(.N(N)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .z     (z),
        .y     (y),
        .r     (r),
        .x     (x),
        .ovf   (ovf),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [3:0] vz;
        logic [3:0] vy;
        logic [3:0] vr;
        logic [7:0] ex;
        logic       eo;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain signed arithmetic and a range test.
    task automatic model(input logic [3:0] mz, input logic [3:0] my, input logic [3:0] mr,
                         output logic [7:0] ex, output logic eo);
        int a, b, c, v;
        a  = $signed(mz);
        b  = $signed(my);
        c  = $signed(mr);
        v  = a * b + c;
        ex = v[7:0];
        eo = (v < -8) || (v > 7);
    endtask

    // Caller is at a negedge. Returns done latency in cycles (-1 if none),
    // the busy-cycle count and whether done was still high a cycle later.
    task automatic run_op(input logic [3:0] oz, input logic [3:0] oy, input logic [3:0] orr,
                          output logic [7:0] xo, output logic oo, output int lat,
                          output int nbusy, output logic done_after);
        z = oz; y = oy; r = orr; start = 1'b1;
        lat = -1; nbusy = 0; xo = 8'h00; oo = 1'b0; done_after = 1'b0;
        @(posedge clk);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) begin
                start = 1'b0;
                z = N'($urandom); y = N'($urandom); r = N'($urandom);
            end
            if (busy) nbusy++;
            if (done) begin
                lat = k; xo = x; oo = ovf;
                break;
            end
        end
        @(negedge clk);
        done_after = done;
    endtask

    vec_t       tbl[8];
    logic [7:0] xo, ex;
    logic       oo, eo, da;
    int         lat, nb, ndone, t1, t2;
    logic [7:0] x1, x2;
    logic       o1, o2;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        tbl[0] = '{4'h3, 4'hE, 4'h1, 8'hFB, 1'b0};
        tbl[1] = '{4'h8, 4'h8, 4'h0, 8'h40, 1'b1};
        tbl[2] = '{4'h8, 4'h7, 4'h8, 8'hC0, 1'b1};
        tbl[3] = '{4'h7, 4'h7, 4'h7, 8'h38, 1'b1};
        tbl[4] = '{4'h0, 4'h0, 4'h0, 8'h00, 1'b0};
        tbl[5] = '{4'hF, 4'hF, 4'h8, 8'hF9, 1'b0};
        tbl[6] = '{4'h7, 4'h8, 4'hF, 8'hC7, 1'b1};
        tbl[7] = '{4'hD, 4'h2, 4'h7, 8'h01, 1'b0};

        rst = 1'b1; start = 1'b0; z = 4'h0; y = 4'h0; r = 4'h0;
        #1;
        check("reset_x", 32'(x), 32'h0);
        check("reset_ovf", 32'(ovf), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_done", 32'(done), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Directed table; the first op starts on the first edge after reset release.
        for (int i = 0; i < 8; i++) begin
            if (i != 0) @(negedge clk);
            run_op(tbl[i].vz, tbl[i].vy, tbl[i].vr, xo, oo, lat, nb, da);
            check($sformatf("tbl%0d_x", i), 32'(xo), 32'(tbl[i].ex));
            check($sformatf("tbl%0d_ovf", i), 32'(oo), 32'(tbl[i].eo));
            check($sformatf("tbl%0d_latency", i), 32'(lat), 32'd6);
            check($sformatf("tbl%0d_busy_cycles", i), 32'(nb), 32'd5);
            check($sformatf("tbl%0d_done_width", i), 32'(da), 32'h0);
            check($sformatf("tbl%0d_x_hold", i), 32'(x), 32'(tbl[i].ex));
        end

        // Start pulses while busy must be ignored.
        @(negedge clk);
        z = 4'h2; y = 4'h3; r = 4'h0; start = 1'b1;
        @(posedge clk);
        ndone = 0; t1 = -1;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (k == 1 || k == 3) begin
                start = 1'b1; z = 4'h7; y = 4'h7; r = 4'h7;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                ndone++;
                if (t1 < 0) begin t1 = k; x1 = x; o1 = ovf; end
            end
        end
        check("ignore_done_count", 32'(ndone), 32'd1);
        check("ignore_latency", 32'(t1), 32'd6);
        check("ignore_x", 32'(x1), 32'h06);
        check("ignore_ovf", 32'(o1), 32'h0);

        // Back-to-back with start held; new operands presented in the DONE cycle.
        @(negedge clk);
        z = 4'h1; y = 4'hF; r = 4'hF; start = 1'b1;
        @(posedge clk);
        t1 = -1; t2 = -1; x1 = 8'h00; x2 = 8'h00; o1 = 1'b0; o2 = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (done) begin
                if (t1 < 0) begin
                    t1 = k; x1 = x; o1 = ovf;
                    z = 4'h0; y = 4'h5; r = 4'h3;
                end else begin
                    t2 = k; x2 = x; o2 = ovf;
                    start = 1'b0;
                    break;
                end
            end
        end
        start = 1'b0;
        check("b2b_first_latency", 32'(t1), 32'd6);
        check("b2b_spacing", 32'(t2 - t1), 32'd6);
        check("b2b_x1", 32'(x1), 32'hFE);
        check("b2b_ovf1", 32'(o1), 32'h0);
        check("b2b_x2", 32'(x2), 32'h03);
        check("b2b_ovf2", 32'(o2), 32'h0);

        // Reset in the middle of an operation.
        @(negedge clk);
        z = 4'h3; y = 4'h3; r = 4'h1; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_x", 32'(x), 32'h0);
        check("abort_ovf", 32'(ovf), 32'h0);
        check("abort_busy", 32'(busy), 32'h0);
        check("abort_done", 32'(done), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("abort_no_done", 32'(ndone), 32'd0);
        @(negedge clk);
        run_op(4'h2, 4'h2, 4'h1, xo, oo, lat, nb, da);
        check("abort_next_x", 32'(xo), 32'h05);
        check("abort_next_latency", 32'(lat), 32'd6);

        // Exhaustive sweep of all operand combinations.
        for (int iz = 0; iz < 16; iz++) begin
            for (int iy = 0; iy < 16; iy++) begin
                for (int ir = 0; ir < 16; ir++) begin
                    @(negedge clk);
                    run_op(4'(iz), 4'(iy), 4'(ir), xo, oo, lat, nb, da);
                    model(4'(iz), 4'(iy), 4'(ir), ex, eo);
                    check($sformatf("exh_x z=%0h y=%0h r=%0h", iz, iy, ir), 32'(xo), 32'(ex));
                    check($sformatf("exh_ovf z=%0h y=%0h r=%0h", iz, iy, ir), 32'(oo), 32'(eo));
                end
            end
        end

        // Random operands, alternating idle gaps.
        for (int i = 0; i < 200; i++) begin
            logic [3:0] a, b, c;
            a = 4'($urandom); b = 4'($urandom); c = 4'($urandom);
            repeat ($urandom_range(1, 3)) @(negedge clk);
            run_op(a, b, c, xo, oo, lat, nb, da);
            model(a, b, c, ex, eo);
            check($sformatf("rnd%0d_x", i), 32'(xo), 32'(ex));
            check($sformatf("rnd%0d_ovf", i), 32'(oo), 32'(eo));
            check($sformatf("rnd%0d_latency", i), 32'(lat), 32'd6);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
